// File: rtl/fpu_pkg.sv
// Shared types for the FP adder result collector.
// FPU_FLUSH_EN adds a squash bit to each tag-pipe stage.
package fpu_pkg;

   localparam int FLOAT_WIDTH = 32;
   localparam int TAG_WIDTH   = 5;

   typedef struct packed {
      logic invalid;
      logic overflow;
      logic underflow;
   } fp_flags_t;

   typedef logic [TAG_WIDTH-1:0] fpu_tag_t;

   typedef struct packed {
      logic [FLOAT_WIDTH-1:0] data;
      fpu_tag_t               tag;
      fp_flags_t              flags;
   } fpu_result_t;

   typedef struct packed {
      logic     v;
`ifdef FPU_FLUSH_EN
      logic     sq;
`endif
      fpu_tag_t tag;
   } tag_stage_t;

endpackage

// File: rtl/fpu_result_collector_if.sv
// Issue / adder-return / writeback bundle of the result collector.
// FPU_FLUSH_EN adds the flush request to the bundle.
interface fpu_result_collector_if #(
   parameter int DEPTH = 8
);
   logic                               issue_valid;
   fpu_pkg::fpu_tag_t                  issue_tag;
   logic                               issue_ready;
   logic                               add_valid;
   logic [fpu_pkg::FLOAT_WIDTH-1:0]    add_data;
   fpu_pkg::fp_flags_t                 add_flags;
   logic                               wb_valid;
   logic                               wb_ready;
   logic [fpu_pkg::FLOAT_WIDTH-1:0]    wb_data;
   fpu_pkg::fpu_tag_t                  wb_tag;
   fpu_pkg::fp_flags_t                 wb_flags;
   logic [$clog2(DEPTH+1)-1:0]         occupancy;
   logic                               proto_err;
`ifdef FPU_FLUSH_EN
   logic                               flush;

   modport master (
      output issue_valid, issue_tag, add_valid, add_data, add_flags, wb_ready, flush,
      input  issue_ready, wb_valid, wb_data, wb_tag, wb_flags, occupancy, proto_err
   );
   modport slave (
      input  issue_valid, issue_tag, add_valid, add_data, add_flags, wb_ready, flush,
      output issue_ready, wb_valid, wb_data, wb_tag, wb_flags, occupancy, proto_err
   );
`else
   modport master (
      output issue_valid, issue_tag, add_valid, add_data, add_flags, wb_ready,
      input  issue_ready, wb_valid, wb_data, wb_tag, wb_flags, occupancy, proto_err
   );
   modport slave (
      input  issue_valid, issue_tag, add_valid, add_data, add_flags, wb_ready,
      output issue_ready, wb_valid, wb_data, wb_tag, wb_flags, occupancy, proto_err
   );
`endif
endinterface

// File: rtl/fpu_tag_pipe.sv
// Destination-tag delay line that tracks the adder's fixed-latency pipe.
// FPU_FLUSH_EN adds the squash input and per-stage squash marking.
module fpu_tag_pipe
   import fpu_pkg::*;
#(
   parameter int LATENCY = 7
)(
   input  logic     clk,
   input  logic     rst,
   input  logic     in_valid,
   input  fpu_tag_t in_tag,
`ifdef FPU_FLUSH_EN
   input  logic     squash,
   output logic     out_sq,
`endif
   output logic     out_valid,
   output fpu_tag_t out_tag
);

   tag_stage_t stage [LATENCY];

   // Stage 0 takes the issued op, every stage ages by one per cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < LATENCY; i++) begin
            stage[i] <= '0;
         end
      end else begin
         stage[0].v   <= in_valid;
         stage[0].tag <= in_tag;
`ifdef FPU_FLUSH_EN
         stage[0].sq  <= 1'b0;
`endif
         for (int i = 1; i < LATENCY; i++) begin
            stage[i] <= stage[i-1];
`ifdef FPU_FLUSH_EN
            stage[i].sq <= stage[i-1].sq | squash;
`endif
         end
      end
   end

   assign out_valid = stage[LATENCY-1].v;
   assign out_tag   = stage[LATENCY-1].tag;
`ifdef FPU_FLUSH_EN
   assign out_sq    = stage[LATENCY-1].sq;
`endif

endmodule

// File: rtl/fpu_result_collector.sv
// Credit issue, tag tracking and result FIFO between the FP adder and writeback.
// FPU_FLUSH_EN adds a flush request that empties the FIFO and squashes in-flight ops.
module fpu_result_collector
   import fpu_pkg::*;
#(
   parameter int PIPE_LATENCY = 7,
   parameter int DEPTH        = 8
)(
   input logic                   clk,
   input logic                   rst,
   fpu_result_collector_if.slave bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   fpu_result_t   mem [DEPTH];
   logic [AW:0]   wr_ptr_r;
   logic [AW:0]   rd_ptr_r;
   logic [AW:0]   wr_ptr_nx;
   logic [AW:0]   rd_ptr_nx;
   logic [CW-1:0] inflight_r;
   logic [CW-1:0] inflight_nx;
   logic [CW-1:0] occ_nx;
   logic [CW:0]   credit_sum;
   logic          ready_r;
   logic          ready_nx;
   logic          proto_err_r;
   logic          err_set;
   logic          flush_now;
   logic          fire;
   logic          empty;
   logic          full;
   logic          live_exit;
   logic          enq;
   logic          deq;
   logic          exit_v;
   logic          exit_sq;
   fpu_tag_t      exit_tag;
   fpu_result_t   head;

`ifdef FPU_FLUSH_EN
   assign flush_now = bus.flush;
`else
   assign flush_now = 1'b0;
   assign exit_sq   = 1'b0;
`endif

   fpu_tag_pipe #(
      .LATENCY (PIPE_LATENCY)
   ) u_tag_pipe (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (fire),
      .in_tag    (bus.issue_tag),
`ifdef FPU_FLUSH_EN
      .squash    (flush_now),
      .out_sq    (exit_sq),
`endif
      .out_valid (exit_v),
      .out_tag   (exit_tag)
   );

   // Match tag-pipe exits against adder returns and work out next pointer/credit state.
   always_comb begin
      fire      = bus.issue_valid & ready_r & ~flush_now;
      empty     = (wr_ptr_r == rd_ptr_r);
      full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
      live_exit = exit_v & ~exit_sq & ~flush_now;
      deq       = ~empty & bus.wb_ready & ~flush_now;
      enq       = 1'b0;
      err_set   = 1'b0;
      if (live_exit & bus.add_valid) begin
         if (full) begin
            err_set = 1'b1;
         end else begin
            enq = 1'b1;
         end
      end else if (bus.add_valid & ~exit_v) begin
         err_set = 1'b1;
      end else if (live_exit) begin
         err_set = 1'b1;
      end else begin
         err_set = 1'b0;
      end
      wr_ptr_nx = wr_ptr_r + {{AW{1'b0}}, enq};
      if (flush_now) begin
         rd_ptr_nx = wr_ptr_r;
      end else begin
         rd_ptr_nx = rd_ptr_r + {{AW{1'b0}}, deq};
      end
      inflight_nx = inflight_r + {{(CW-1){1'b0}}, fire} - {{(CW-1){1'b0}}, exit_v};
      occ_nx      = CW'(wr_ptr_nx - rd_ptr_nx);
      // Credit is precomputed from next state so issue_ready never sees wb_ready or add_valid.
      credit_sum  = {1'b0, occ_nx} + {1'b0, inflight_nx};
      ready_nx    = (credit_sum < (CW+1)'(DEPTH));
   end

   // Pointer, credit and sticky error registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r    <= '0;
         rd_ptr_r    <= '0;
         inflight_r  <= '0;
         ready_r     <= 1'b1;
         proto_err_r <= 1'b0;
      end else begin
         wr_ptr_r    <= wr_ptr_nx;
         rd_ptr_r    <= rd_ptr_nx;
         inflight_r  <= inflight_nx;
         ready_r     <= ready_nx;
         proto_err_r <= proto_err_r | err_set;
      end
   end

   // Result storage, written only for matched, unsquashed returns.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (enq) begin
         mem[wr_ptr_r[AW-1:0]] <= '{data: bus.add_data, tag: exit_tag, flags: bus.add_flags};
      end
   end

   assign head            = mem[rd_ptr_r[AW-1:0]];
   assign bus.issue_ready = ready_r & ~flush_now;
   assign bus.wb_valid    = ~empty;
   assign bus.wb_data     = empty ? '0 : head.data;
   assign bus.wb_tag      = empty ? '0 : head.tag;
   assign bus.wb_flags    = empty ? '0 : head.flags;
   assign bus.occupancy   = CW'(wr_ptr_r - rd_ptr_r);
   assign bus.proto_err   = proto_err_r;

endmodule

// File: tb/tb_fpu_result_collector.sv
// Self-checking bench: queue-based reference model plus directed and random stimulus.
module tb_fpu_result_collector;

   localparam int L = 7;
   localparam int D = 8;

   typedef struct { int due; logic [4:0] tag; bit sq; } pend_t;
   typedef struct { int due; logic [31:0] data; logic [2:0] flags; } ret_t;
   typedef struct { logic [31:0] data; logic [4:0] tag; logic [2:0] flags; } res_t;

   logic clk;
   logic rst;
   logic fl_in;

   fpu_result_collector_if #(.DEPTH(D)) bus ();

   fpu_result_collector #(.PIPE_LATENCY(L), .DEPTH(D)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

`ifdef FPU_FLUSH_EN
   assign bus.flush = fl_in;
`endif

   pend_t pend[$];
   ret_t  adq[$];
   res_t  exp_q[$];
   bit    exp_err;
   int    cyc;
   int    n_checks;
   int    n_pass;
   bit    mon_en;
   bit    suppress;
   bit    force_en;
   logic [31:0] force_val;
   res_t  mon_h;
   bit    mon_v;

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
   endtask

   // Reference model: advances one clock using the inputs sampled at this edge.
   task automatic model_step();
      bit fl, rdy, fire, ex, ex_live, full_pre, enq, deq, av;
      pend_t e;
      pend_t t;
      logic [31:0] d;
      if (rst) begin
         exp_q.delete(); pend.delete(); adq.delete(); exp_err = 0;
         return;
      end
      fl  = fl_in;
      av  = bus.add_valid;
      rdy = (exp_q.size() + pend.size() < D) && !fl;
      fire = bus.issue_valid && rdy;
      ex = 0;
      e = '{0, 5'd0, 1'b0};
      if (pend.size() > 0 && pend[0].due == cyc) begin
         ex = 1;
         e = pend.pop_front();
      end
      ex_live  = ex && !e.sq && !fl;
      full_pre = (exp_q.size() == D);
      deq      = (exp_q.size() > 0) && bus.wb_ready && !fl;
      enq      = 0;
      if (ex_live && av) begin
         if (full_pre) exp_err = 1;
         else enq = 1;
      end else if (!ex && av) begin
         exp_err = 1;
      end else if (ex_live && !av) begin
         exp_err = 1;
      end
      if (deq) void'(exp_q.pop_front());
      if (enq) exp_q.push_back('{bus.add_data, e.tag, bus.add_flags});
      if (fl) begin
         exp_q.delete();
         for (int i = 0; i < pend.size(); i++) begin
            t = pend[i]; t.sq = 1; pend[i] = t;
         end
      end
      if (fire) begin
         d = force_en ? force_val : $urandom;
         force_en = 0;
         pend.push_back('{cyc + L, bus.issue_tag, 1'b0});
         adq.push_back('{cyc + L, d, 3'($urandom)});
      end
   endtask

   // Adder stand-in: returns each accepted op exactly L cycles after issue.
   task automatic drive_adder();
      ret_t r;
      bus.add_valid = 1'b0;
      bus.add_data  = '0;
      bus.add_flags = '0;
      if (adq.size() > 0 && adq[0].due == cyc) begin
         r = adq.pop_front();
         if (suppress) begin
            suppress = 0;
         end else begin
            bus.add_valid = 1'b1;
            bus.add_data  = r.data;
            bus.add_flags = r.flags;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      cyc++;
      #1;
      drive_adder();
   endtask

   task automatic do_reset();
      bus.issue_valid = 0; bus.add_valid = 0; fl_in = 0;
      suppress = 0; force_en = 0;
      rst = 1;
      exp_q.delete(); pend.delete(); adq.delete(); exp_err = 0;
      tick();
      rst = 0;
   endtask

   // Cycle-by-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (mon_en) begin
         mon_v = (exp_q.size() != 0);
         chk("wb_valid", bus.wb_valid, mon_v);
         if (mon_v) begin
            mon_h = exp_q[0];
            chk("wb_data", bus.wb_data, mon_h.data);
            chk("wb_tag", bus.wb_tag, mon_h.tag);
            chk("wb_flags", bus.wb_flags, mon_h.flags);
         end else begin
            chk("wb_data_idle", bus.wb_data, 0);
         end
         chk("occupancy", bus.occupancy, exp_q.size());
         chk("issue_ready", bus.issue_ready, (exp_q.size() + pend.size() < D) && !fl_in);
         chk("proto_err", bus.proto_err, exp_err);
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: actual timeout required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int fires, got;
      bit deq_now;
      clk = 0; rst = 1; fl_in = 0; cyc = 0;
      n_checks = 0; n_pass = 0; mon_en = 1;
      bus.issue_valid = 0; bus.issue_tag = '0; bus.add_valid = 0;
      bus.add_data = '0; bus.add_flags = '0; bus.wb_ready = 0;
      do_reset();
      chk("rst_issue_ready", bus.issue_ready, 1);
      chk("rst_wb_valid", bus.wb_valid, 0);

      // single op round trip with fixed data
      bus.wb_ready = 1; bus.issue_valid = 1; bus.issue_tag = 5'd3;
      force_en = 1; force_val = 32'h40400000;
      tick();
      bus.issue_valid = 0;
      repeat (6) tick();
      chk("t1_no_fallthrough", bus.wb_valid, 0);
      tick();
      chk("t1_wb_valid", bus.wb_valid, 1);
      chk("t1_wb_data", bus.wb_data, 32'h40400000);
      chk("t1_wb_tag", bus.wb_tag, 5'd3);
      tick();
      chk("t1_occ_after", bus.occupancy, 0);

      // credit exhaustion with writeback stalled
      bus.wb_ready = 0; fires = 0;
      for (int i = 0; i < 20; i++) begin
         bus.issue_valid = 1; bus.issue_tag = 5'(fires);
         if (bus.issue_ready) fires++;
         tick();
      end
      bus.issue_valid = 0;
      repeat (8) tick();
      chk("t2_fires", fires, 8);
      chk("t2_occ_full", bus.occupancy, 8);
      chk("t2_ready_low", bus.issue_ready, 0);

      // in-order drain with toggling wb_ready
      got = 0;
      for (int i = 0; i < 40 && got < 8; i++) begin
         bus.wb_ready = (i % 2 == 0);
         deq_now = bus.wb_valid && bus.wb_ready;
         if (deq_now) begin
            chk("t3_order", bus.wb_tag, 5'(got));
            if (got == 0) chk("t3_ready_before", bus.issue_ready, 0);
            got++;
         end
         tick();
         if (deq_now && got == 1) chk("t3_ready_after", bus.issue_ready, 1);
      end
      chk("t3_count", got, 8);

      // return with nothing in flight
      bus.wb_ready = 1;
      bus.add_valid = 1; bus.add_data = 32'h3f800000;
      tick();
      chk("t4_proto_err", bus.proto_err, 1);
      chk("t4_occ", bus.occupancy, 0);

      // reset with ops in flight, then a clean op
      for (int i = 1; i <= 3; i++) begin
         bus.issue_valid = 1; bus.issue_tag = 5'(i);
         tick();
      end
      bus.issue_valid = 0;
      tick();
      do_reset();
      chk("t5_ready", bus.issue_ready, 1);
      chk("t5_wb_valid", bus.wb_valid, 0);
      chk("t5_occ", bus.occupancy, 0);
      chk("t5_err", bus.proto_err, 0);
      bus.wb_ready = 0; bus.issue_valid = 1; bus.issue_tag = 5'd9;
      tick();
      bus.issue_valid = 0;
      for (int i = 0; i < 20 && !bus.wb_valid; i++) tick();
      chk("t5_ret_valid", bus.wb_valid, 1);
      chk("t5_ret_tag", bus.wb_tag, 5'd9);
      chk("t5_ret_err", bus.proto_err, 0);
      bus.wb_ready = 1;
      tick();

      // random traffic, occasional faults, flushes and resets
      for (int c = 0; c < 3000; c++) begin
         bus.issue_valid = ($urandom_range(0, 3) != 0);
         bus.issue_tag   = 5'($urandom);
         if ((c / 200) % 2 == 0) bus.wb_ready = ($urandom_range(0, 3) != 0);
         else bus.wb_ready = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 399) == 0 && !bus.add_valid) begin
            bus.add_valid = 1; bus.add_data = $urandom; bus.add_flags = 3'($urandom);
         end
         if ($urandom_range(0, 399) == 0) suppress = 1;
`ifdef FPU_FLUSH_EN
         fl_in = ($urandom_range(0, 99) == 0);
`endif
         if ($urandom_range(0, 499) == 0) do_reset();
         else tick();
      end
      fl_in = 0;
      bus.issue_valid = 0;

`ifdef FPU_FLUSH_EN
      // flush with 4 queued and 2 in flight
      do_reset();
      bus.wb_ready = 0;
      for (int i = 0; i < 4; i++) begin
         bus.issue_valid = 1; bus.issue_tag = 5'(i);
         tick();
      end
      bus.issue_valid = 0;
      repeat (8) tick();
      chk("t6_occ_before", bus.occupancy, 4);
      bus.issue_valid = 1;
      repeat (2) tick();
      bus.issue_valid = 0;
      tick();
      fl_in = 1;
      tick();
      fl_in = 0;
      chk("t6_occ_flushed", bus.occupancy, 0);
      chk("t6_wb_valid", bus.wb_valid, 0);
      repeat (8) tick();
      chk("t6_err", bus.proto_err, 0);
      chk("t6_occ_after", bus.occupancy, 0);
      chk("t6_ready", bus.issue_ready, 1);
`endif

      repeat (2) tick();
      mon_en = 0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
